// File: rtl/seven_seg_multi_ctrl.sv
// seven_seg_multi_ctrl: Avalon-MM slave driving NUM_DIGITS seven-segment digits.
// Each digit can show a hex-decoded value or a raw segment pattern, with
// per-digit blanking and blinking and a shift-in register for scrolling text.
module seven_seg_multi_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] out_port
);

  localparam int              CW        = $clog2(BLINK_DIV);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(BLINK_DIV - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO  = CW'(0);
  localparam logic [6:0]      SEG_DARK  = ACTIVE_LOW ? 7'h7F : 7'h00;

  localparam logic [3:0] ADDR_DECODE = 4'd8;
  localparam logic [3:0] ADDR_BLANK  = 4'd9;
  localparam logic [3:0] ADDR_BLINK  = 4'd10;
  localparam logic [3:0] ADDR_STATUS = 4'd11;
  localparam logic [3:0] ADDR_SHIFT  = 4'd12;

  // Hex value to active-high segment pattern (bit0 = a .. bit6 = g).
  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [6:0]              r_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   r_decode;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [NUM_DIGITS-1:0]   r_blink;
  logic [CW-1:0]           r_cnt;
  logic                    r_phase;
  logic [7*NUM_DIGITS-1:0] r_out;

  logic                    w_wr;
  logic                    w_blink_wr;
  logic [6:0]              w_digit_pad [8];
  logic [6:0]              w_lit;
  logic [7*NUM_DIGITS-1:0] w_seg;
  logic [31:0]             w_rdata;
  logic                    w_unused;

  assign w_wr       = chipselect & ~write_n;
  assign w_blink_wr = w_wr & (address == ADDR_BLINK);
  assign w_unused   = ^writedata[31:7];

  // Pad the digit array to eight entries so unused digit addresses read as zero.
  for (genvar g = 0; g < 8; g++) begin : g_pad
    if (g < NUM_DIGITS) begin : g_real
      assign w_digit_pad[g] = r_digit[g];
    end else begin : g_zero
      assign w_digit_pad[g] = 7'h00;
    end
  end

  // Register file: digit, mask and shift-in writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= 7'h00;
      r_decode <= {NUM_DIGITS{1'b1}};
      r_blank  <= {NUM_DIGITS{1'b1}};
      r_blink  <= {NUM_DIGITS{1'b0}};
    end else if (w_wr) begin
      case (address)
        ADDR_DECODE: r_decode <= writedata[NUM_DIGITS-1:0];
        ADDR_BLANK:  r_blank  <= writedata[NUM_DIGITS-1:0];
        ADDR_BLINK:  r_blink  <= writedata[NUM_DIGITS-1:0];
        ADDR_STATUS: r_blink  <= r_blink;
        ADDR_SHIFT: begin
          for (int i = NUM_DIGITS - 1; i > 0; i--) r_digit[i] <= r_digit[i-1];
          r_digit[0] <= writedata[6:0];
        end
        default: begin
          // Only addresses below NUM_DIGITS match a digit; the rest are ignored.
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (address == 4'(i)) r_digit[i] <= writedata[6:0];
          end
        end
      endcase
    end
  end

  // Free-running blink divider; a BLINK write restarts it and wins over a wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= CNT_ZERO;
      r_phase <= 1'b0;
    end else if (w_blink_wr) begin
      r_cnt   <= CNT_ZERO;
      r_phase <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt   <= CNT_ZERO;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CNT_ONE;
    end
  end

  // Per-digit segment selection: blank, then blink-off, then decoded/raw pattern.
  always_comb begin
    w_seg = {(7*NUM_DIGITS){1'b0}};
    w_lit = 7'h00;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_blank[i]) begin
        w_lit = 7'h00;
      end else if (r_blink[i] && r_phase) begin
        w_lit = 7'h00;
      end else if (r_decode[i]) begin
        w_lit = hex_decode(r_digit[i][3:0]);
      end else begin
        w_lit = r_digit[i];
      end
      w_seg[7*i +: 7] = ACTIVE_LOW ? ~w_lit : w_lit;
    end
  end

  // Registered segment output, one clock behind the register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= {NUM_DIGITS{SEG_DARK}};
    end else begin
      r_out <= w_seg;
    end
  end

  // Zero-wait-state read mux, not gated by chipselect.
  always_comb begin
    w_rdata = 32'h0000_0000;
    case (address)
      ADDR_DECODE: w_rdata = 32'(r_decode);
      ADDR_BLANK:  w_rdata = 32'(r_blank);
      ADDR_BLINK:  w_rdata = 32'(r_blink);
      ADDR_STATUS: w_rdata = {31'h0000_0000, r_phase};
      ADDR_SHIFT:  w_rdata = 32'h0000_0000;
      default: begin
        if (address[3] == 1'b0) begin
          w_rdata = {25'h000_0000, w_digit_pad[address[2:0]]};
        end else begin
          w_rdata = 32'h0000_0000;
        end
      end
    endcase
  end

  assign readdata = w_rdata;
  assign out_port = r_out;

endmodule

// File: tb/tb_seven_seg_multi_ctrl.sv
// Directed self-checking bench for seven_seg_multi_ctrl (N=8, BLINK_DIV=4, active-low).
module tb_seven_seg_multi_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [55:0] out_port;

  int checks   = 0;
  int failures = 0;

  seven_seg_multi_ctrl #(
    .NUM_DIGITS(8),
    .BLINK_DIV (4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  function automatic logic [6:0] dig(input int i);
    return out_port[7*i +: 7];
  endfunction

  initial begin
    reset      = 1'b1;
    address    = 4'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("out_in_reset", out_port, 56'hFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("out_after_reset", out_port, 56'hFF_FFFF_FFFF_FFFF);
    rd("rd_blank_rst", 4'd9, 32'hFF);
    rd("rd_decode_rst", 4'd8, 32'hFF);
    rd("rd_status_rst", 4'd11, 32'h0);
    rd("rd_blink_rst", 4'd10, 32'h0);

    // Hex decode path
    wr(4'd9, 32'h0);
    wr(4'd0, 32'h5);
    wr(4'd1, 32'hB);
    @(posedge clk);
    #1;
    check("hex_d0_5", dig(0), 7'h12);
    check("hex_d1_b", dig(1), 7'h03);
    check("hex_d2_0", dig(2), 7'h40);

    // Raw segment path
    wr(4'd8, 32'hFE);
    wr(4'd0, 32'h49);
    @(posedge clk);
    #1;
    check("raw_d0", dig(0), 7'h36);
    check("raw_d1_still_hex", dig(1), 7'h03);
    rd("rd_digit0", 4'd0, 32'h49);
    rd("rd_decode", 4'd8, 32'hFE);

    // Shift-in
    wr(4'd12, 32'h1);
    wr(4'd12, 32'h2);
    wr(4'd12, 32'h3);
    rd("shift_d0", 4'd0, 32'h3);
    rd("shift_d1", 4'd1, 32'h2);
    rd("shift_d2", 4'd2, 32'h1);
    rd("shift_d3", 4'd3, 32'h49);
    for (int v = 4; v <= 9; v++) wr(4'd12, 32'(v));
    rd("shift9_d0", 4'd0, 32'h9);
    rd("shift9_d7", 4'd7, 32'h2);
    rd("rd_shift_reg", 4'd12, 32'h0);
    @(posedge clk);
    #1;
    check("shift_out_d0_raw9", dig(0), 7'h76);
    check("shift_out_d1_hex8", dig(1), 7'h00);

    // Blink: restart, then rewrite on the first wrap edge (phase would become 1)
    wr(4'd10, 32'h01);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      address = 4'd11;
      #1;
      check("blink_pre_phase", readdata, 32'h0);
      check("blink_pre_d0", dig(0), 7'h76);
    end
    wr(4'd10, 32'h01);
    address = 4'd11;
    #1;
    check("blink_wrap_clear", readdata, 32'h0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      address = 4'd11;
      #1;
      check("blink_phase", readdata, ((k / 4) % 2 == 1) ? 32'h1 : 32'h0);
      check("blink_d0", dig(0), (((k - 1) / 4) % 2 == 1) ? 7'h7F : 7'h76);
      check("blink_d1_steady", dig(1), 7'h00);
    end

    // Asynchronous reset while phase=1 with digit data loaded
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out", out_port, 56'hFF_FFFF_FFFF_FFFF);
    rd("rst_status", 4'd11, 32'h0);
    rd("rst_digit0", 4'd0, 32'h0);
    rd("rst_digit7", 4'd7, 32'h0);
    rd("rst_decode", 4'd8, 32'hFF);
    rd("rst_blank", 4'd9, 32'hFF);
    rd("rst_blink", 4'd10, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Unmapped and read-only addresses
    wr(4'd14, 32'h1234_5678);
    rd("rd_addr14", 4'd14, 32'h0);
    wr(4'd11, 32'hFFFF_FFFF);
    rd("status_ro", 4'd11, 32'h0);
    rd("rd_addr13", 4'd13, 32'h0);
    rd("rd_addr15", 4'd15, 32'h0);
    @(posedge clk);
    #1;
    check("out_dark_end", out_port, 56'hFF_FFFF_FFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
